// File: rtl/rle_encoder_pkg.sv
// Shared types and helpers for the run-length coefficient encoder:
// symbol record, block geometry constants and size/amplitude calculation.
package rle_encoder_pkg;

  localparam int unsigned COEF_W       = 10;
  localparam int unsigned AC_PER_BLOCK = 63;
  localparam int unsigned ZRL_RUN      = 15;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned MAX_PUSH     = 4;

  typedef struct packed {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
  } sym_t;

  typedef enum logic {
    ST_WAIT_DC,
    ST_IN_BLOCK
  } enc_state_t;

  localparam sym_t ZRL_SYM = '{run: 4'(ZRL_RUN), size: 4'd0, amp: '0};
  localparam sym_t EOB_SYM = '{run: 4'd0, size: 4'd0, amp: '0};

  // Magnitude is taken one bit wider so that -512 yields 512 and size 10.
  function automatic sym_t make_sym(input logic [3:0] run, input logic [COEF_W-1:0] coef);
    sym_t              s;
    logic [COEF_W:0]   mag;
    logic [COEF_W:0]   one_hot;
    logic [COEF_W-1:0] mask;
    logic [COEF_W-1:0] adj;
    mag = coef[COEF_W-1] ? (~{coef[COEF_W-1], coef} + (COEF_W+1)'(1)) : {1'b0, coef};
    s.run  = run;
    s.size = '0;
    for (int unsigned i = 0; i <= COEF_W; i++) begin
      if (mag[i]) s.size = 4'(i + 1);
    end
    one_hot = (COEF_W+1)'(1) << s.size;
    mask    = one_hot[COEF_W-1:0] - COEF_W'(1);
    adj     = coef[COEF_W-1] ? (coef - COEF_W'(1)) : coef;
    s.amp   = adj & mask;
    return s;
  endfunction

endpackage

// File: rtl/rle_encoder_sym_fifo.sv
// Symbol FIFO: up to MAX_PUSH_N writes and one read per cycle; the head is
// registered straight onto the outputs. Overflowing bursts are dropped whole.
module sym_fifo
  import rle_encoder_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_PUSH_N = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [$clog2(MAX_PUSH_N+1)-1:0]    push_n,
  input  sym_t [MAX_PUSH_N-1:0]              push_data,
  output logic                               ovf,
  output logic                               out_valid,
  output sym_t                               out_sym
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  sym_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   fill_after;
  logic          pop;

  always_comb begin
    pop        = (count != '0);
    fill_after = {1'b0, count} + (CW+1)'(push_n) - (CW+1)'(pop);
    ovf        = (fill_after > (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!ovf) begin
      for (int unsigned i = 0; i < MAX_PUSH_N; i++) begin
        if (i < 32'(push_n)) mem[wr_ptr + PW'(i)] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
    end else begin
      out_valid <= pop;
      out_sym   <= pop ? mem[rd_ptr] : '0;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (!ovf) begin
        wr_ptr <= wr_ptr + PW'(push_n);
        count  <= fill_after[CW-1:0];
      end else begin
        count  <= count - CW'(pop);
      end
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder for zigzag-ordered AC coefficients: emits ZRL/EOB and
// (run, size, amp) symbols through a small FIFO; flags truncated blocks.
module rle_encoder
  import rle_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              dc_valid,
  input  logic              ac_valid,
  output logic              sym_valid,
  output logic [3:0]        sym_run,
  output logic [3:0]        sym_size,
  output logic [COEF_W-1:0] sym_amp,
  output logic              block_err
);

  enc_state_t           state;
  logic [5:0]           ac_cnt;
  logic [3:0]           zero_run;
  logic [1:0]           zrl_pend;

  logic                 ac_take;
  logic                 coef_nz;
  logic                 last_term;
  logic [2:0]           push_n;
  sym_t [MAX_PUSH-1:0]  push_data;
  logic                 fifo_ovf;
  sym_t                 out_sym;

  always_comb begin
    ac_take   = ac_valid && !dc_valid && (state == ST_IN_BLOCK) &&
                (ac_cnt != 6'(AC_PER_BLOCK));
    coef_nz   = (coef_in != '0);
    last_term = (ac_cnt == 6'(AC_PER_BLOCK - 1));
  end

  // Pending ZRLs fill the low slots; the coefficient symbol follows them.
  always_comb begin
    push_n = '0;
    for (int unsigned i = 0; i < MAX_PUSH; i++) push_data[i] = ZRL_SYM;
    if (ac_take && coef_nz) begin
      push_data[zrl_pend] = make_sym(zero_run, coef_in);
      push_n              = {1'b0, zrl_pend} + 3'd1;
    end else if (ac_take && last_term) begin
      push_data[0] = EOB_SYM;
      push_n       = 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_WAIT_DC;
      ac_cnt    <= '0;
      zero_run  <= '0;
      zrl_pend  <= '0;
      block_err <= 1'b0;
    end else begin
      block_err <= fifo_ovf;
      if (dc_valid) begin
        if (ac_cnt != '0 && ac_cnt != 6'(AC_PER_BLOCK)) block_err <= 1'b1;
        state    <= ST_IN_BLOCK;
        ac_cnt   <= '0;
        zero_run <= '0;
        zrl_pend <= '0;
      end else if (ac_take) begin
        ac_cnt <= ac_cnt + 6'd1;
        if (coef_nz || last_term) begin
          zero_run <= '0;
          zrl_pend <= '0;
        end else if (zero_run == 4'(ZRL_RUN)) begin
          zero_run <= '0;
          zrl_pend <= zrl_pend + 2'd1;
        end else begin
          zero_run <= zero_run + 4'd1;
        end
      end
    end
  end

  sym_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .MAX_PUSH_N (MAX_PUSH)
  ) u_sym_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_n    (push_n),
    .push_data (push_data),
    .ovf       (fifo_ovf),
    .out_valid (sym_valid),
    .out_sym   (out_sym)
  );

  always_comb begin
    sym_run  = out_sym.run;
    sym_size = out_sym.size;
    sym_amp  = out_sym.amp;
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Bench for rle_encoder: directed blocks plus randomized blocks, checked
// cycle by cycle against a queue-based reference of the encoding rules.
module tb_rle_encoder;
  import rle_encoder_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [COEF_W-1:0] coef_in;
  logic              dc_valid;
  logic              ac_valid;
  logic              sym_valid;
  logic [3:0]        sym_run;
  logic [3:0]        sym_size;
  logic [COEF_W-1:0] sym_amp;
  logic              block_err;

  rle_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .coef_in   (coef_in),
    .dc_valid  (dc_valid),
    .ac_valid  (ac_valid),
    .sym_valid (sym_valid),
    .sym_run   (sym_run),
    .sym_size  (sym_size),
    .sym_amp   (sym_amp),
    .block_err (block_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int run;
    int size;
    int amp;
    int due;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_due = 0;
  bit    m_open  = 0;
  int    m_nac   = 0;
  int    m_zeros = 0;
  bit    exp_err = 0;
  string phase   = "reset";
  int    n_sym   = 0;
  int    n_err   = 0;
  int    last_run, last_size, last_amp;
  int    blk[63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int size_of(input int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m > 0) begin
      s++;
      m = m / 2;
    end
    return s;
  endfunction

  function automatic int amp_of(input int v);
    int s = size_of(v);
    return (v >= 0) ? v : ((v - 1) & ((1 << s) - 1));
  endfunction

  // A symbol pushed at edge N shows at N+1, then one per cycle behind the backlog.
  function automatic void model_push(input int run, input int size, input int amp);
    exp_t e;
    int   d = cyc + 1;
    if (last_due + 1 > d) d = last_due + 1;
    last_due = d;
    e.run = run; e.size = size; e.amp = amp; e.due = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(input bit dc, input bit ac, input int c);
    exp_err = 0;
    if (dc) begin
      exp_err = m_open && (m_nac > 0) && (m_nac < 63);
      m_open  = 1;
      m_nac   = 0;
      m_zeros = 0;
    end else if (ac && m_open && m_nac < 63) begin
      if (c != 0) begin
        for (int k = 0; k < m_zeros / 16; k++) model_push(15, 0, 0);
        model_push(m_zeros % 16, size_of(c), amp_of(c));
        m_zeros = 0;
      end else if (m_nac == 62) begin
        model_push(0, 0, 0);
      end else begin
        m_zeros++;
      end
      m_nac++;
    end
  endfunction

  task automatic check_outputs();
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check({phase, ".valid"}, 32'(sym_valid), 1);
      check({phase, ".run"},   32'(sym_run),   exp_q[0].run);
      check({phase, ".size"},  32'(sym_size),  exp_q[0].size);
      check({phase, ".amp"},   32'(sym_amp),   exp_q[0].amp);
      last_run  = int'(sym_run);
      last_size = int'(sym_size);
      last_amp  = int'(sym_amp);
      n_sym++;
      void'(exp_q.pop_front());
    end else begin
      check({phase, ".idle"}, 32'(sym_valid), 0);
    end
    check({phase, ".err"}, 32'(block_err), 32'(exp_err));
    if (block_err === 1'b1) n_err++;
  endtask

  task automatic cycle(input bit dc, input bit ac, input int c);
    dc_valid = dc;
    ac_valid = ac;
    coef_in  = 10'(c);
    @(posedge clk);
    cyc++;
    model_step(dc, ac, c);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0);
  endtask

  function automatic int rand_coef();
    case ($urandom_range(7))
      0:       return -512;
      1:       return 511;
      2:       return ($urandom_range(1) == 1) ? 1 : -1;
      default: return int'($urandom_range(1023)) - 512;
    endcase
  endfunction

  task automatic send_block(input int gap_pct, input int abort_at, input bit ac_with_dc);
    cycle(1, ac_with_dc, int'($urandom_range(1023)) - 512);
    for (int i = 0; i < 63; i++) begin
      if (i == abort_at) return;
      while (int'($urandom_range(99)) < gap_pct) cycle(0, 0, int'($urandom_range(1023)) - 512);
      cycle(0, 1, blk[i]);
    end
  endtask

  task automatic start_phase(input string name);
    phase = name;
    n_sym = 0;
    n_err = 0;
  endtask

  initial begin
    reset = 1'b1; dc_valid = 1'b0; ac_valid = 1'b0; coef_in = '0;
    @(posedge clk); cyc++; #1;
    check("rst.valid", 32'(sym_valid), 0);
    check("rst.run",   32'(sym_run),   0);
    check("rst.size",  32'(sym_size),  0);
    check("rst.amp",   32'(sym_amp),   0);
    check("rst.err",   32'(block_err), 0);
    @(posedge clk); cyc++; #1;
    reset = 1'b0;

    start_phase("pre_dc");
    cycle(0, 1, 5); cycle(0, 1, 0); cycle(0, 1, -7);
    idle(3);
    check("pre_dc.nsym", n_sym, 0);

    start_phase("blk037");
    foreach (blk[i]) blk[i] = 0;
    blk[0] = 5; blk[3] = -3;
    send_block(0, -1, 0);
    idle(4);
    check("blk037.nsym", n_sym, 3);
    check("blk037.last_run", last_run, 0);
    check("blk037.last_size", last_size, 0);
    check("blk037.nerr", n_err, 0);

    start_phase("blk038");
    foreach (blk[i]) blk[i] = 0;
    blk[40] = 7;
    send_block(0, -1, 0);
    idle(4);
    check("blk038.nsym", n_sym, 4);

    start_phase("blk040");
    foreach (blk[i]) blk[i] = 0;
    send_block(0, -1, 0);
    idle(3);
    check("blk040.nsym", n_sym, 1);

    start_phase("blk041");
    foreach (blk[i]) blk[i] = rand_coef();
    send_block(0, 10, 0);
    send_block(0, -1, 0);
    idle(4);
    check("blk041.nerr", n_err, 1);

    start_phase("blk039");
    foreach (blk[i]) blk[i] = 0;
    blk[62] = -512;
    send_block(0, -1, 0);
    idle(6);
    check("blk039.nsym", n_sym, 4);
    check("blk039.last_run", last_run, 14);
    check("blk039.last_size", last_size, 10);
    check("blk039.last_amp", last_amp, 511);

    start_phase("rst_mid");
    foreach (blk[i]) blk[i] = 0;
    blk[62] = -512;
    send_block(0, -1, 0);
    cycle(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid.valid", 32'(sym_valid), 0);
    check("rst_mid.run",   32'(sym_run),   0);
    check("rst_mid.size",  32'(sym_size),  0);
    check("rst_mid.err",   32'(block_err), 0);
    exp_q.delete();
    m_open = 0; m_nac = 0; m_zeros = 0; last_due = 0; exp_err = 0;
    @(posedge clk); cyc++; #1;
    check("rst_mid.hold", 32'(sym_valid), 0);
    reset = 1'b0;
    cycle(0, 1, 9); cycle(0, 1, 0);
    idle(6);
    check("rst_mid.nsym", n_sym, 1);

    start_phase("rand");
    for (int b = 0; b < 40; b++) begin
      int dens = int'($urandom_range(100));
      int abrt = ($urandom_range(99) < 15) ? int'($urandom_range(62, 1)) : -1;
      foreach (blk[i]) blk[i] = (int'($urandom_range(99)) < dens) ? rand_coef() : 0;
      send_block(int'($urandom_range(30)), abrt, $urandom_range(3) == 0);
      if ($urandom_range(3) == 0) begin
        cycle(0, 1, rand_coef());
        idle(int'($urandom_range(3)));
      end
    end
    idle(10);
    check("final.drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
